rob_flex: RTL and testbench
===========================

Name: rob_flex

Overview:
- Parametrised, multi-ported reorder buffer; next generation of the core's in-order retirement queue.
- Sits between dispatch (allocation) and retirement (architectural commit / freelist release).
- Adds over the previous ROB:
  - independent dispatch, commit and writeback widths;
  - a valid/ready dispatch handshake;
  - a commit back-pressure input;
  - precise recovery with two flavours: a mispredicted branch retires and then flushes younger entries; an excepting instruction flushes itself and everything younger.

Parameters:
DEPTH, 32, number of entries; power of two, >= 4
DISPATCH_W, 2, entries allocated per cycle
COMMIT_W, 2, entries retired per cycle
WB_PORTS, 3, writeback (CDB) ports
PAYLOAD_W, 48, opaque per-entry payload (dest prn/arn, PC etc.); stored and returned unchanged
IDX_W, $clog2(DEPTH), entry index width

Ports:
clock  in  1  single clock
reset  in  1  asynchronous, active-low reset
dispatch_valid  in  DISPATCH_W  per-lane allocate request
dispatch_payload  in  DISPATCH_W*PAYLOAD_W  per-lane payload
dispatch_ready  out  1  all-or-nothing accept for the whole group
dispatch_robn  out  DISPATCH_W*IDX_W  index assigned to lane k = tail + (number of valid lanes below k), mod DEPTH
wb_valid  in  WB_PORTS  completion strobe
wb_robn  in  WB_PORTS*IDX_W  completing entry
wb_mispredict  in  WB_PORTS  branch resolved against its prediction
wb_exception  in  WB_PORTS  instruction faulted
wb_target  in  WB_PORTS*32  redirect PC: correct target for mispredict, handler PC for exception
commit_ready  in  1  retirement consumer can accept this cycle
commit_valid  out  COMMIT_W  lane retires this cycle
commit_payload  out  COMMIT_W*PAYLOAD_W  payload of retiring lane
squash  out  1  flush pulse
squash_pc  out  32  fetch redirect target; valid only while squash = 1
count  out  IDX_W+1  occupied entries
empty  out  1  count == 0

Behaviour:
- State:
  - head and tail pointers of IDX_W+1 bits (wrap bit); count = tail - head.
  - Per entry: valid, executed, mispredict, exception, target[31:0], payload.
- Reset (asynchronous on reset low):
  - head = tail = 0; all valid, executed, mispredict and exception bits = 0.
  - Effect on outputs is immediate: commit_valid = 0, squash = 0, squash_pc = 0, count = 0, empty = 1, dispatch_ready = 1.
  - Payload storage is not reset.
- Dispatch:
  - dispatch_ready = ((DEPTH - count) >= DISPATCH_W) && !squash, computed from registered count only. Same-cycle commits do not free space.
  - Handshake fires when dispatch_ready && |dispatch_valid.
  - Valid lanes are written compacted at consecutive indices from tail, with executed/mispredict/exception cleared; tail advances by popcount(dispatch_valid).
  - dispatch_valid while not ready: nothing is written; the requester holds.
- Writeback:
  - For each port with wb_valid whose target entry is valid: set executed; latch mispredict, exception and target.
  - Writeback to an invalid entry is ignored.
  - Two ports naming the same entry in one cycle: the higher port index wins.
  - All writebacks are ignored in a squash cycle.
  - Writeback is visible to commit one cycle later; there is no same-cycle bypass.
- Commit (combinational from registered state; takes effect at the clock edge):
  - Lane i examines entry head+i.
  - Lane i is eligible iff commit_ready, entry valid, entry executed, all lanes < i eligible and committed, and no lane < i raised squash.
  - Plain entry: commit_valid[i] = 1.
  - Mispredict entry: commit_valid[i] = 1, squash = 1, squash_pc = its target; lanes > i are 0.
  - Exception entry: commit_valid[i] = 0, squash = 1, squash_pc = its target; lanes >= i are 0. Exception has priority over mispredict on the same entry.
  - head advances by the number of committed lanes; retired entries are invalidated.
  - commit_ready = 0: no lane commits and no squash is raised.
- Squash:
  - At the clock edge: all entries invalidated, head = tail = 0, count = 0.
  - Dispatch is blocked that cycle.
  - squash lasts exactly one cycle per event.
- Wrap-around:
  - Indices are taken mod DEPTH; the wrap bit disambiguates full (count == DEPTH) from empty.
  - Commit lanes never read past tail.

Test Plan:
- Reset low mid-operation with count = 7 -> count = 0, empty = 1, commit_valid = 0 immediately, before any clock edge; dispatch_ready = 1 after release.
- DEPTH = 8, DISPATCH_W = 2, dispatch_valid = 2'b10 three times -> dispatch_robn = 0, 1, 2; count = 3; no holes.
- Fill to count = 7 -> dispatch_ready = 0; commit 1 entry -> dispatch_ready = 1 the following cycle, not the same cycle.
- Entries 0, 1, 2 executed; entry 1 mispredict, target 0x1040 -> commit_valid = 2'b11, squash = 1, squash_pc = 0x1040; next cycle count = 0 and entry 2 is never committed.
- Entry 0 with both exception and mispredict, target 0x0800 -> commit_valid = 0, squash = 1, squash_pc = 0x0800; exception takes priority.
- Wrap: DEPTH = 8, run 20 dispatch/commit pairs -> payloads retire in order; count never exceeds 8; head and tail wrap correctly.
- commit_ready = 0 with 4 executed entries -> commit_valid = 0, squash = 0, head unchanged.

Source files
------------

// File: rtl/rob_flex_if.sv
// Interface between the reorder buffer and its neighbours: dispatch allocation,
// writeback (CDB) completions, and in-order retirement with flush signalling.
interface rob_flex_if #(
  parameter int DEPTH      = 32,
  parameter int DISPATCH_W = 2,
  parameter int COMMIT_W   = 2,
  parameter int WB_PORTS   = 3,
  parameter int PAYLOAD_W  = 48,
  parameter int IDX_W      = $clog2(DEPTH)
);
  logic [DISPATCH_W-1:0]           dispatch_valid;
  logic [DISPATCH_W*PAYLOAD_W-1:0] dispatch_payload;
  logic                            dispatch_ready;
  logic [DISPATCH_W*IDX_W-1:0]     dispatch_robn;
  logic [WB_PORTS-1:0]             wb_valid;
  logic [WB_PORTS*IDX_W-1:0]       wb_robn;
  logic [WB_PORTS-1:0]             wb_mispredict;
  logic [WB_PORTS-1:0]             wb_exception;
  logic [WB_PORTS*32-1:0]          wb_target;
  logic                            commit_ready;
  logic [COMMIT_W-1:0]             commit_valid;
  logic [COMMIT_W*PAYLOAD_W-1:0]   commit_payload;
  logic                            squash;
  logic [31:0]                     squash_pc;
  logic [IDX_W:0]                  count;
  logic                            empty;

  modport master (
    output dispatch_valid, dispatch_payload, wb_valid, wb_robn, wb_mispredict,
           wb_exception, wb_target, commit_ready,
    input  dispatch_ready, dispatch_robn, commit_valid, commit_payload, squash,
           squash_pc, count, empty
  );

  modport slave (
    input  dispatch_valid, dispatch_payload, wb_valid, wb_robn, wb_mispredict,
           wb_exception, wb_target, commit_ready,
    output dispatch_ready, dispatch_robn, commit_valid, commit_payload, squash,
           squash_pc, count, empty
  );
endinterface

// File: rtl/rob_flex.sv
// Multi-ported reorder buffer: grouped dispatch, multi-port writeback, in-order
// commit with precise recovery (mispredict retires then flushes; exception flushes itself).
module rob_flex #(
  parameter int DEPTH      = 32,
  parameter int DISPATCH_W = 2,
  parameter int COMMIT_W   = 2,
  parameter int WB_PORTS   = 3,
  parameter int PAYLOAD_W  = 48,
  parameter int IDX_W      = $clog2(DEPTH)
) (
  input logic       clock,
  input logic       reset,
  rob_flex_if.slave bus
);
  logic [IDX_W:0]         head_r;
  logic [IDX_W:0]         tail_r;
  logic [DEPTH-1:0]       valid_r;
  logic [DEPTH-1:0]       exec_r;
  logic [DEPTH-1:0]       mis_r;
  logic [DEPTH-1:0]       exc_r;
  logic [31:0]            target_r  [DEPTH];
  logic [PAYLOAD_W-1:0]   payload_r [DEPTH];

  logic [IDX_W:0]         count_s;
  logic [IDX_W:0]         free_s;
  logic                   dispatch_ready_s;
  logic                   dispatch_fire_s;
  logic [IDX_W-1:0]       disp_idx_s [DISPATCH_W];
  logic [IDX_W:0]         disp_cnt_s;
  logic [IDX_W-1:0]       wb_idx_s   [WB_PORTS];
  logic [COMMIT_W-1:0]    commit_valid_s;
  logic [IDX_W-1:0]       commit_idx_s [COMMIT_W];
  logic [IDX_W:0]         commit_cnt_s;
  logic                   squash_s;
  logic [31:0]            squash_pc_s;

  // Occupancy and all-or-nothing dispatch acceptance, from registered pointers only
  assign count_s          = tail_r - head_r;
  assign free_s           = (IDX_W+1)'(DEPTH) - count_s;
  assign dispatch_ready_s = (free_s >= (IDX_W+1)'(DISPATCH_W)) && !squash_s;
  assign dispatch_fire_s  = dispatch_ready_s && (|bus.dispatch_valid);

  // Compacted lane-to-index assignment: each valid lane takes the next free slot
  always_comb begin
    logic [IDX_W:0] run_s;
    run_s = '0;
    for (int k = 0; k < DISPATCH_W; k++) begin
      disp_idx_s[k] = tail_r[IDX_W-1:0] + run_s[IDX_W-1:0];
      if (bus.dispatch_valid[k]) begin
        run_s = run_s + (IDX_W+1)'(1);
      end else begin
        run_s = run_s;
      end
    end
    disp_cnt_s = run_s;
  end

  // Unpack writeback entry indices
  always_comb begin
    for (int p = 0; p < WB_PORTS; p++) begin
      wb_idx_s[p] = bus.wb_robn[p*IDX_W +: IDX_W];
    end
  end

  // Commit lane selection; the first lane that cannot retire or raises a flush stops younger lanes
  always_comb begin
    logic stop_s;
    commit_valid_s = '0;
    commit_cnt_s   = '0;
    squash_s       = 1'b0;
    squash_pc_s    = 32'h0;
    stop_s         = !bus.commit_ready;
    for (int i = 0; i < COMMIT_W; i++) begin
      commit_idx_s[i] = head_r[IDX_W-1:0] + IDX_W'(i);
      if (stop_s || ((IDX_W+1)'(i) >= count_s) ||
          !valid_r[commit_idx_s[i]] || !exec_r[commit_idx_s[i]]) begin
        stop_s = 1'b1;
      end else if (exc_r[commit_idx_s[i]]) begin
        squash_s    = 1'b1;
        squash_pc_s = target_r[commit_idx_s[i]];
        stop_s      = 1'b1;
      end else begin
        commit_valid_s[i] = 1'b1;
        commit_cnt_s      = commit_cnt_s + (IDX_W+1)'(1);
        if (mis_r[commit_idx_s[i]]) begin
          squash_s    = 1'b1;
          squash_pc_s = target_r[commit_idx_s[i]];
          stop_s      = 1'b1;
        end else begin
          stop_s = stop_s;
        end
      end
    end
  end

  // Pointers and per-entry status; a flush empties the buffer and restarts at index 0
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      head_r  <= '0;
      tail_r  <= '0;
      valid_r <= '0;
      exec_r  <= '0;
      mis_r   <= '0;
      exc_r   <= '0;
    end else if (squash_s) begin
      head_r  <= '0;
      tail_r  <= '0;
      valid_r <= '0;
      exec_r  <= '0;
      mis_r   <= '0;
      exc_r   <= '0;
    end else begin
      // Ascending port order lets the highest port win on a shared entry
      for (int p = 0; p < WB_PORTS; p++) begin
        if (bus.wb_valid[p] && valid_r[wb_idx_s[p]]) begin
          exec_r[wb_idx_s[p]] <= 1'b1;
          mis_r[wb_idx_s[p]]  <= bus.wb_mispredict[p];
          exc_r[wb_idx_s[p]]  <= bus.wb_exception[p];
        end
      end
      for (int i = 0; i < COMMIT_W; i++) begin
        if (commit_valid_s[i]) begin
          valid_r[commit_idx_s[i]] <= 1'b0;
        end
      end
      head_r <= head_r + commit_cnt_s;
      if (dispatch_fire_s) begin
        for (int k = 0; k < DISPATCH_W; k++) begin
          if (bus.dispatch_valid[k]) begin
            valid_r[disp_idx_s[k]] <= 1'b1;
            exec_r[disp_idx_s[k]]  <= 1'b0;
            mis_r[disp_idx_s[k]]   <= 1'b0;
            exc_r[disp_idx_s[k]]   <= 1'b0;
          end
        end
        tail_r <= tail_r + disp_cnt_s;
      end
    end
  end

  // Entry data storage, deliberately without reset
  always_ff @(posedge clock) begin
    if (!squash_s) begin
      for (int p = 0; p < WB_PORTS; p++) begin
        if (bus.wb_valid[p] && valid_r[wb_idx_s[p]]) begin
          target_r[wb_idx_s[p]] <= bus.wb_target[p*32 +: 32];
        end
      end
      if (dispatch_fire_s) begin
        for (int k = 0; k < DISPATCH_W; k++) begin
          if (bus.dispatch_valid[k]) begin
            payload_r[disp_idx_s[k]] <= bus.dispatch_payload[k*PAYLOAD_W +: PAYLOAD_W];
          end
        end
      end
    end
  end

  // Output packing; idle commit lanes return zero instead of stale payload
  always_comb begin
    bus.dispatch_robn  = '0;
    bus.commit_payload = '0;
    for (int k = 0; k < DISPATCH_W; k++) begin
      bus.dispatch_robn[k*IDX_W +: IDX_W] = disp_idx_s[k];
    end
    for (int i = 0; i < COMMIT_W; i++) begin
      if (commit_valid_s[i]) begin
        bus.commit_payload[i*PAYLOAD_W +: PAYLOAD_W] = payload_r[commit_idx_s[i]];
      end else begin
        bus.commit_payload[i*PAYLOAD_W +: PAYLOAD_W] = '0;
      end
    end
  end

  assign bus.dispatch_ready = dispatch_ready_s;
  assign bus.commit_valid   = commit_valid_s;
  assign bus.squash         = squash_s;
  assign bus.squash_pc      = squash_pc_s;
  assign bus.count          = count_s;
  assign bus.empty          = (count_s == '0);
endmodule

// File: tb/tb_rob_flex.sv
// Randomised scoreboard bench for rob_flex (DEPTH = 8): a queue-based reference
// model predicts retirements and flushes; a separate monitor checks them.
module tb_rob_flex;
  localparam int D  = 8;
  localparam int DW = 2;
  localparam int CW = 2;
  localparam int WP = 3;
  localparam int PW = 48;
  localparam int IW = 3;

  typedef struct {
    logic [PW-1:0] payload;
    bit            ex;
    bit            mis;
    bit            exc;
    logic [31:0]   target;
  } ent_t;

  logic clock = 1'b0;
  logic reset = 1'b0;
  int   errors = 0;
  int   checks = 0;

  ent_t          mq[$];
  int            base = 0;
  logic [PW-1:0] exp_pay[$];
  logic [31:0]   exp_pc[$];

  logic [WP-1:0]    pw_v = '0;
  logic [WP-1:0]    pw_mis = '0;
  logic [WP-1:0]    pw_exc = '0;
  logic [WP*IW-1:0] pw_robn = '0;
  logic [WP*32-1:0] pw_tgt = '0;

  rob_flex_if #(.DEPTH(D), .DISPATCH_W(DW), .COMMIT_W(CW), .WB_PORTS(WP), .PAYLOAD_W(PW)) bus ();

  rob_flex #(.DEPTH(D), .DISPATCH_W(DW), .COMMIT_W(CW), .WB_PORTS(WP), .PAYLOAD_W(PW)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic setwb(input int port, input int robn, input bit mis, input bit exc,
                       input logic [31:0] tgt);
    pw_v[port]               = 1'b1;
    pw_robn[port*IW +: IW]   = IW'(robn);
    pw_mis[port]             = mis;
    pw_exc[port]             = exc;
    pw_tgt[port*32 +: 32]    = tgt;
  endtask

  function automatic int newest();
    return (base + mq.size() - 1) % D;
  endfunction

  // Reference model step: predicts this cycle's outputs and the state after the edge
  task automatic step();
    int               n;
    int               ncom;
    int               below;
    int               pos;
    bit               done;
    bit               sq;
    bit               rdy;
    logic [31:0]      pc;
    logic [CW-1:0]    ecv;
    ent_t             e;
    #1;
    n = mq.size();
    chk("count", 64'(bus.count), 64'(n));
    chk("empty", 64'(bus.empty), 64'(n == 0));
    ecv = '0; sq = 1'b0; pc = 32'h0; ncom = 0;
    done = !bus.commit_ready;
    for (int i = 0; i < CW; i++) begin
      if (!done) begin
        if (i >= n) begin
          done = 1'b1;
        end else if (!mq[i].ex) begin
          done = 1'b1;
        end else if (mq[i].exc) begin
          sq = 1'b1; pc = mq[i].target; done = 1'b1;
        end else begin
          ecv[i] = 1'b1;
          ncom++;
          exp_pay.push_back(mq[i].payload);
          if (mq[i].mis) begin
            sq = 1'b1; pc = mq[i].target; done = 1'b1;
          end
        end
      end
    end
    if (sq) exp_pc.push_back(pc);
    chk("commit_valid", 64'(bus.commit_valid), 64'(ecv));
    chk("squash", 64'(bus.squash), 64'(sq));
    rdy = ((D - n) >= DW) && !sq;
    chk("dispatch_ready", 64'(bus.dispatch_ready), 64'(rdy));
    below = 0;
    for (int k = 0; k < DW; k++) begin
      if (bus.dispatch_valid[k]) begin
        chk("dispatch_robn", 64'(bus.dispatch_robn[k*IW +: IW]), 64'((base + n + below) % D));
        below++;
      end
    end
    if (!sq) begin
      for (int p = 0; p < WP; p++) begin
        if (bus.wb_valid[p]) begin
          pos = (int'(bus.wb_robn[p*IW +: IW]) - base + D) % D;
          if (pos < n) begin
            e        = mq[pos];
            e.ex     = 1'b1;
            e.mis    = bus.wb_mispredict[p];
            e.exc    = bus.wb_exception[p];
            e.target = bus.wb_target[p*32 +: 32];
            mq[pos]  = e;
          end
        end
      end
    end
    if (rdy && (bus.dispatch_valid != '0)) begin
      for (int k = 0; k < DW; k++) begin
        if (bus.dispatch_valid[k]) begin
          e.payload = bus.dispatch_payload[k*PW +: PW];
          e.ex = 1'b0; e.mis = 1'b0; e.exc = 1'b0; e.target = 32'h0;
          mq.push_back(e);
        end
      end
    end
    if (sq) begin
      mq.delete();
      base = 0;
    end else begin
      repeat (ncom) void'(mq.pop_front());
      base = (base + ncom) % D;
    end
  endtask

  task automatic tick(input logic [DW-1:0] dv, input bit cr);
    logic [63:0] r;
    @(negedge clock);
    bus.dispatch_valid = dv;
    bus.commit_ready   = cr;
    for (int k = 0; k < DW; k++) begin
      r = {$urandom(), $urandom()};
      bus.dispatch_payload[k*PW +: PW] = r[PW-1:0];
    end
    bus.wb_valid      = pw_v;
    bus.wb_robn       = pw_robn;
    bus.wb_mispredict = pw_mis;
    bus.wb_exception  = pw_exc;
    bus.wb_target     = pw_tgt;
    pw_v = '0; pw_mis = '0; pw_exc = '0;
    step();
  endtask

  task automatic rst_checks();
    chk("rst_count", 64'(bus.count), 64'(0));
    chk("rst_empty", 64'(bus.empty), 64'(1));
    chk("rst_commit_valid", 64'(bus.commit_valid), 64'(0));
    chk("rst_squash", 64'(bus.squash), 64'(0));
    chk("rst_squash_pc", 64'(bus.squash_pc), 64'(0));
  endtask

  // Asynchronous reset mid-cycle with commit enabled; outputs must clear before any edge
  task automatic reset_mid();
    @(negedge clock);
    bus.dispatch_valid = '0;
    bus.wb_valid       = '0;
    bus.commit_ready   = 1'b1;
    #1 reset = 1'b0;
    #1 rst_checks();
    mq.delete();
    base = 0;
    #5 reset = 1'b1;
  endtask

  // Monitor: pops the scoreboard whenever the DUT retires a lane or flushes
  initial begin
    forever begin
      @(negedge clock);
      #2;
      if (reset) begin
        for (int i = 0; i < CW; i++) begin
          if (bus.commit_valid[i]) begin
            if (exp_pay.size() == 0) begin
              checks++; errors++;
              $display("FAIL commit_unexpected: lane %0d payload %0h, none expected", i,
                       bus.commit_payload[i*PW +: PW]);
            end else begin
              chk("commit_payload", 64'(bus.commit_payload[i*PW +: PW]), 64'(exp_pay.pop_front()));
            end
          end
        end
        if (bus.squash) begin
          if (exp_pc.size() == 0) begin
            checks++; errors++;
            $display("FAIL squash_unexpected: pc %0h, none expected", bus.squash_pc);
          end else begin
            chk("squash_pc", 64'(bus.squash_pc), 64'(exp_pc.pop_front()));
          end
        end
      end
    end
  end

  initial begin
    bus.dispatch_valid   = '0;
    bus.dispatch_payload = '0;
    bus.wb_valid         = '0;
    bus.wb_robn          = '0;
    bus.wb_mispredict    = '0;
    bus.wb_exception     = '0;
    bus.wb_target        = '0;
    bus.commit_ready     = 1'b0;
    #3 rst_checks();
    #14 reset = 1'b1;

    // Sparse lane-1-only dispatch packs at 0,1,2; then fill to 7 and try past full
    repeat (3) tick(2'b10, 1'b0);
    setwb(0, 0, 1'b0, 1'b0, 32'h0);
    setwb(1, 1, 1'b0, 1'b0, 32'h0);
    tick(2'b11, 1'b0);
    tick(2'b11, 1'b0);
    tick(2'b11, 1'b0);
    reset_mid();

    // Refill to 7, retire one: ready returns only the cycle after
    repeat (3) tick(2'b11, 1'b0);
    tick(2'b01, 1'b0);
    setwb(0, 0, 1'b0, 1'b0, 32'h0);
    tick(2'b00, 1'b0);
    tick(2'b00, 1'b1);
    tick(2'b00, 1'b0);
    reset_mid();

    // Mispredict at entry 1: two lanes retire, entry 2 is flushed
    tick(2'b11, 1'b0);
    tick(2'b01, 1'b0);
    setwb(0, 0, 1'b0, 1'b0, 32'h0);
    setwb(1, 1, 1'b1, 1'b0, 32'h0000_1040);
    setwb(2, 2, 1'b0, 1'b0, 32'h0);
    tick(2'b00, 1'b0);
    tick(2'b00, 1'b1);
    tick(2'b00, 1'b1);

    // Exception plus mispredict on one entry: exception wins, nothing retires
    tick(2'b01, 1'b0);
    setwb(0, 0, 1'b1, 1'b1, 32'h0000_0800);
    tick(2'b00, 1'b0);
    tick(2'b00, 1'b1);

    // Same entry on two ports: the higher port's plain completion wins
    tick(2'b01, 1'b0);
    setwb(0, 0, 1'b0, 1'b1, 32'h0000_dead);
    setwb(2, 0, 1'b0, 1'b0, 32'h0000_0123);
    tick(2'b00, 1'b0);
    tick(2'b00, 1'b1);

    // Four executed entries held by commit_ready low, then released
    tick(2'b11, 1'b0);
    tick(2'b11, 1'b0);
    for (int j = 0; j < 3; j++) setwb(j, (base + j) % D, 1'b0, 1'b0, 32'h0);
    tick(2'b00, 1'b0);
    setwb(0, (base + 3) % D, 1'b0, 1'b0, 32'h0);
    tick(2'b00, 1'b0);
    tick(2'b00, 1'b0);
    tick(2'b00, 1'b1);
    tick(2'b00, 1'b1);

    // Wrap: steady dispatch/complete/retire across the index boundary
    for (int j = 0; j < 20; j++) begin
      if (mq.size() > 0) setwb(0, newest(), 1'b0, 1'b0, 32'h0);
      tick(2'b01, 1'b1);
    end

    // Randomised traffic
    for (int j = 0; j < 600; j++) begin
      for (int p = 0; p < WP; p++) begin
        if ($urandom_range(1, 0) == 1) begin
          int r;
          if (mq.size() > 0 && $urandom_range(7, 0) != 0) r = (base + int'($urandom % mq.size())) % D;
          else r = int'($urandom_range(D - 1, 0));
          setwb(p, r, $urandom_range(15, 0) == 0, $urandom_range(31, 0) == 0, $urandom);
        end
      end
      tick(DW'($urandom_range(3, 0)), $urandom_range(3, 0) != 0);
    end

    tick(2'b00, 1'b0);
    #5;
    chk("payload_queue_drained", 64'(exp_pay.size()), 64'(0));
    chk("squash_queue_drained", 64'(exp_pc.size()), 64'(0));
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
